// File: rtl/outport_uart_tx.sv
// outport_uart_tx: buffers 32-bit Out_Port writes in a small FIFO and sends
// each word as four UART frames, least-significant byte first.
// Frames are 8N1 by default. Defining OUTPORT_UART_TX_PARITY_EN inserts an
// even-parity bit, which makes each frame 8E1.
module outport_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             Out_portIn,
    input  logic [31:0]                      BusMuxOut,
    output logic                             tx,
    output logic                             busy,
    output logic                             fifo_empty,
    output logic                             fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);

`ifdef OUTPORT_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [31:0]     shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
`ifdef OUTPORT_UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            empty_w;
    logic            full_w;
    logic            pop;
    logic            push;
    logic            bit_end;

    // FIFO status and the push/pop decisions for this edge
    always_comb begin
        empty_w = (count_q == '0);
        full_w  = (count_q == CW'(FIFO_DEPTH));
        pop     = (state_q == S_IDLE) && !empty_w;
        // A pop on the same edge frees a slot, so a write to a full FIFO is still accepted.
        push    = Out_portIn && (!full_w || pop);
        bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));
    end

    // FIFO pointer, occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (Out_portIn && full_w && !pop);
    end

    // Serializer next-state: frame sequencing, bit timer and registered line value
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (pop) begin
                    state_d = S_START;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    // The whole word shifts right, so the next byte ends up in [7:0].
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef OUTPORT_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef OUTPORT_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (byte_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = S_START;
                    end
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef OUTPORT_UART_TX_PARITY_EN
        // The byte about to be sent is in shift[7:0] for as long as START lasts.
        parity_d = parity_q;
        if (state_d == S_START) begin
            parity_d = ^shift_d[7:0];
        end
`endif

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef OUTPORT_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // All control state, with an asynchronous clear that aborts any frame in progress
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
`ifdef OUTPORT_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
`ifdef OUTPORT_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // FIFO storage. It needs no reset because the pointers define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= BusMuxOut;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_empty = empty_w;
    assign fifo_full  = full_w;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_outport_uart_tx.sv
// tb_outport_uart_tx: directed and randomized checks of outport_uart_tx.
// The line is decoded independently of the DUT, and the expected words come from
// a queue model of the FIFO and of the word time.
`timescale 1ns/1ps
module tb_outport_uart_tx;

    localparam int C    = 4;
    localparam int D    = 4;
`ifdef OUTPORT_UART_TX_PARITY_EN
    localparam int FB   = 11;
`else
    localparam int FB   = 10;
`endif
    localparam int FL   = FB * C;
    localparam int WORD = 4 * FL;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        wr = 1'b0;
    logic [31:0] data = '0;
    logic        tx, busy, fifo_empty, fifo_full, overflow;
    logic [$clog2(D+1)-1:0] fifo_count;

    int checks = 0;
    int failures = 0;

    outport_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clock(clk), .clear(clear), .Out_portIn(wr), .BusMuxOut(data),
        .tx(tx), .busy(busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: word queue plus word-time countdown
    logic [31:0] m_q[$];
    logic [31:0] m_sent[$];
    int          m_rem = 0;
    bit          m_ovf = 0;
    bit          m_pop;

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            m_q.delete(); m_sent.delete(); m_rem = 0; m_ovf = 0;
        end else begin
            m_pop = (m_rem == 0) && (m_q.size() != 0);
            if (m_pop) m_sent.push_back(m_q.pop_front());
            if (wr) begin
                if (m_q.size() < D) m_q.push_back(data);
                else m_ovf = 1;
            end
            if (m_pop) m_rem = WORD;
            else if (m_rem > 0) m_rem--;
        end
    end

    // ---------------- line monitor: decodes frames from per-cycle samples
    logic        fbuf [FL];
    logic [31:0] rx_words[$];
    int          rx_gaps[$];
    int          mon_err = 0, mon_frames = 0;
    int          ncyc = 0, mpos = 0, start_cyc = 0, end_cyc = 0, nb = 0;
    bit          in_frame = 0, have_end = 0, ferr;
    logic [7:0]  rb;
    logic [31:0] wacc;

    always @(negedge clk) begin
        if (clear === 1'b1) begin
            in_frame = 0; have_end = 0; nb = 0; wacc = '0;
            mon_err = 0; mon_frames = 0;
            rx_words.delete(); rx_gaps.delete();
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1; mpos = 0; start_cyc = ncyc;
            end
            if (in_frame) begin
                fbuf[mpos] = tx;
                mpos++;
                if (mpos == FL) begin
                    ferr = 0;
                    for (int b = 0; b < FB; b++)
                        for (int s = 1; s < C; s++)
                            if (fbuf[b*C+s] !== fbuf[b*C]) ferr = 1;
                    if (fbuf[0] !== 1'b0) ferr = 1;
                    for (int k = 0; k < 8; k++) rb[k] = fbuf[(k+1)*C];
`ifdef OUTPORT_UART_TX_PARITY_EN
                    if (fbuf[9*C] !== ^rb) ferr = 1;
`endif
                    if (fbuf[(FB-1)*C] !== 1'b1) ferr = 1;
                    if (ferr) mon_err++;
                    rx_gaps.push_back(have_end ? start_cyc - end_cyc - 1 : -1);
                    mon_frames++;
                    end_cyc = ncyc; have_end = 1; in_frame = 0;
                    wacc[8*nb +: 8] = rb;
                    nb++;
                    if (nb == 4) begin
                        rx_words.push_back(wacc);
                        nb = 0;
                    end
                end
            end
        end
        ncyc++;
    end

    // ---------------- stimulus utilities
    task automatic do_clear();
        @(posedge clk); #1 clear = 1'b1; wr = 1'b0;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 6 * WORD + 50; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && fifo_empty === 1'b1 && m_rem == 0 && m_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        clear = 1'b1; wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
        checks++; if (fifo_count !== 0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        #1 clear = 1'b0;
    endtask

    task automatic test_single(input logic [31:0] w);
        int errs;
        int b, f;
        logic [7:0] bv;
        logic e;
        do_clear();
        @(negedge clk); wr = 1'b1; data = w;
        @(posedge clk); #1;
        wr = 1'b0;
        checks++; if (fifo_count !== 1) begin failures++; $display("FAIL single_count_after_write: got %0d expected 1", fifo_count); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL single_idle_after_write: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
        @(posedge clk); #1;
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 0) begin
            failures++; $display("FAIL single_pop_edge: got tx=%b busy=%b count=%0d expected tx=0 busy=1 count=0", tx, busy, fifo_count);
        end
        errs = 0;
        for (int i = 0; i < WORD; i++) begin
            @(negedge clk);
            b  = i / FL;
            f  = (i % FL) / C;
            bv = w[8*b +: 8];
            if (f == 0) e = 1'b0;
            else if (f <= 8) e = bv[f-1];
            else if (FB == 11 && f == 9) e = ^bv;
            else e = 1'b1;
            if (tx !== e) errs++;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL single_bit_sequence %h: got %0d wrong samples expected 0", w, errs); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_last_cycle: got %b expected 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL single_busy_fall: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
        checks++; if (rx_words.size() != 1 || rx_words[0] !== w || mon_err != 0) begin
            failures++; $display("FAIL single_rx_word: got %0d words first=%h frame_errs=%0d expected 1 word %h", rx_words.size(), (rx_words.size() > 0) ? rx_words[0] : 32'h0, mon_err, w);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w [6];
        bit ok;
        int errs;
        do_clear();
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); wr = 1'b1; data = w[i];
            @(posedge clk); #1;
            if (i == 4) begin
                checks++; if (fifo_count !== 4 || fifo_full !== 1'b1 || overflow !== 1'b0) begin
                    failures++; $display("FAIL ovf_fill: got count=%0d full=%b ovf=%b expected 4 1 0", fifo_count, fifo_full, overflow);
                end
            end
        end
        checks++; if (overflow !== 1'b1 || fifo_count !== 4) begin
            failures++; $display("FAIL ovf_drop: got ovf=%b count=%0d expected 1 4", overflow, fifo_count);
        end
        @(negedge clk); wr = 1'b0;
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_drain_timeout: got busy=%b expected 0", busy); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        errs = 0;
        for (int i = 0; i < 5; i++) if (i >= rx_words.size() || rx_words[i] !== w[i]) errs++;
        checks++; if (errs != 0 || rx_words.size() != 5 || mon_err != 0) begin
            failures++; $display("FAIL ovf_line_words: got %0d words %0d wrong frame_errs=%0d expected 5 words W1..W5", rx_words.size(), errs, mon_err);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] w [6];
        bit ok, seen;
        int errs;
        do_clear();
        for (int i = 0; i < 6; i++) w[i] = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wr = 1'b1; data = w[i];
            @(posedge clk);
        end
        @(negedge clk); wr = 1'b0;
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL fullpop_full: got %b expected 1", fifo_full); end
        seen = 0;
        for (int i = 0; i < WORD + 20; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin seen = 1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL fullpop_idle_timeout: got busy=%b expected 0", busy); end
        wr = 1'b1; data = w[5];
        @(posedge clk); #1;
        checks++; if (fifo_count !== 4 || overflow !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL fullpop_accept: got count=%0d ovf=%b busy=%b expected 4 0 1", fifo_count, overflow, busy);
        end
        @(negedge clk); wr = 1'b0;
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL fullpop_drain_timeout: got busy=%b expected 0", busy); end
        errs = 0;
        for (int i = 0; i < 6; i++) if (i >= rx_words.size() || rx_words[i] !== w[i]) errs++;
        checks++; if (errs != 0 || rx_words.size() != 6 || mon_err != 0) begin
            failures++; $display("FAIL fullpop_line_words: got %0d words %0d wrong frame_errs=%0d expected 6 words", rx_words.size(), errs, mon_err);
        end
    endtask

    task automatic test_abort();
        int errs;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wr = 1'b1; data = $urandom;
            @(posedge clk);
        end
        @(negedge clk); wr = 1'b0;
        checks++; if (fifo_count !== 3) begin failures++; $display("FAIL abort_queued: got %0d expected 3", fifo_count); end
        repeat (2 * FL) @(posedge clk);
        #1;
        checks++; if (mon_frames != 2 || tx !== 1'b0 && busy !== 1'b1) begin
            failures++; $display("FAIL abort_in_byte2: got frames=%0d busy=%b expected 2 1", mon_frames, busy);
        end
        clear = 1'b1;
        #1;
        checks++; if (tx !== 1'b1 || fifo_count !== 0 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
            failures++; $display("FAIL abort_immediate: got tx=%b count=%0d busy=%b empty=%b expected 1 0 0 1", tx, fifo_count, busy, fifo_empty);
        end
        @(posedge clk); #1 clear = 1'b0;
        errs = 0;
        for (int i = 0; i < 2 * WORD; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        checks++; if (errs != 0 || mon_frames != 0) begin
            failures++; $display("FAIL abort_quiet_line: got %0d active samples %0d frames expected 0 0", errs, mon_frames);
        end
    endtask

    task automatic test_back_to_back();
        int exp_gaps [8];
        bit ok;
        int errs;
        exp_gaps = '{-1, 0, 0, 0, 1, 0, 0, 0};
        do_clear();
        @(negedge clk); wr = 1'b1; data = 32'h12345678;
        @(posedge clk);
        @(negedge clk); data = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk); wr = 1'b0;
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_drain_timeout: got busy=%b expected 0", busy); end
        checks++; if (rx_words.size() != 2 || rx_words[0] !== 32'h12345678 || rx_words[1] !== 32'hFFFFFFFF || mon_err != 0) begin
            failures++; $display("FAIL b2b_words: got %0d words [%h %h] frame_errs=%0d expected 12345678 ffffffff",
                rx_words.size(), (rx_words.size() > 0) ? rx_words[0] : 32'h0, (rx_words.size() > 1) ? rx_words[1] : 32'h0, mon_err);
        end
        errs = 0;
        for (int i = 0; i < 8; i++) if (i >= rx_gaps.size() || rx_gaps[i] != exp_gaps[i]) errs++;
        checks++; if (errs != 0 || rx_gaps.size() != 8) begin
            failures++; $display("FAIL b2b_gaps: got %0d frames %0d wrong gaps expected 8 frames, gaps -,0,0,0,1,0,0,0", rx_gaps.size(), errs);
        end
    endtask

    task automatic test_random();
        bit ok;
        int errs;
        int rate;
        do_clear();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++; if (fifo_count !== m_q.size()) begin failures++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", c, fifo_count, m_q.size()); end
            checks++; if (busy !== (m_rem > 0)) begin failures++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", c, busy, m_rem > 0); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow cyc %0d: got %b expected %b", c, overflow, m_ovf); end
            checks++; if (fifo_empty !== (m_q.size() == 0) || fifo_full !== (m_q.size() == D)) begin
                failures++; $display("FAIL rnd_flags cyc %0d: got empty=%b full=%b expected size %0d", c, fifo_empty, fifo_full, m_q.size());
            end
            rate = (c < 400) ? 2 : 60;
            wr   = ($urandom_range(rate - 1) == 0);
            data = $urandom;
        end
        @(negedge clk); wr = 1'b0;
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rnd_drain_timeout: got busy=%b expected 0", busy); end
        errs = 0;
        for (int i = 0; i < m_sent.size(); i++) if (i >= rx_words.size() || rx_words[i] !== m_sent[i]) errs++;
        checks++; if (errs != 0 || rx_words.size() != m_sent.size() || mon_err != 0) begin
            failures++; $display("FAIL rnd_line_words: got %0d words %0d wrong frame_errs=%0d expected %0d words", rx_words.size(), errs, mon_err, m_sent.size());
        end
    endtask

    initial begin
        test_reset();
        test_single(32'h000000A5);
        test_single(32'h00000301);
        test_overflow();
        test_full_pop();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
